// File: rtl/scan_datapath.sv
// Scan datapath: a preloadable source RAM, a read-address counter, an
// unsigned threshold comparator, a destination RAM and a saturating
// write/match counter. Sequencing is owned by the external scan controller.
// This block only reacts to the controller's strobes and reports rco/gt back
// with zero latency.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset (clears counters only)
//   clr                 synchronous clear of both counters, dominates all strobes
//   rd_inc              advance read address (wraps at the top)
//   wr_inc              advance write/match counter (saturates at 2**ADDR_W)
//   we                  store current source word at wr_count in destination RAM
//   thresh              unsigned comparison threshold
//   load_en/addr/data   source RAM preload write port
//   dst_addr            destination RAM readback address
//   rd_addr, src_data   current read address and the source word there
//   gt, rco             src_data > thresh; rd_addr at its last address
//   wr_count, full      words stored (also next destination slot); counter saturated
//   dst_data            destination RAM word at dst_addr
module scan_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_inc,
  input  logic              wr_inc,
  input  logic              we,
  input  logic [DATA_W-1:0] thresh,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] src_data,
  output logic              gt,
  output logic              rco,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic [DATA_W-1:0] dst_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] src_mem [DEPTH];
  logic [DATA_W-1:0] dst_mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              full_w;
  logic              dst_we;

  assign full_w = (wr_count_q == FULL_CNT);
  // A write issued together with clr, or once all slots are used, is dropped
  // so earlier results are never overwritten on the counter's behalf.
  assign dst_we = we & ~clr & ~full_w;

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (clr) begin
      rd_addr_d = '0;
    end else if (rd_inc) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (clr) begin
      wr_count_d = '0;
    end else if (wr_inc && !full_w) begin
      wr_count_d = wr_count_q + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q  <= '0;
      wr_count_q <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // RAM contents survive reset; only the counters are cleared.
  always_ff @(posedge clk) begin
    if (load_en) begin
      src_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (dst_we) begin
      dst_mem[wr_count_q[ADDR_W-1:0]] <= src_mem[rd_addr_q];
    end
  end

  assign rd_addr  = rd_addr_q;
  assign src_data = src_mem[rd_addr_q];
  assign gt       = (src_mem[rd_addr_q] > thresh);
  assign rco      = (rd_addr_q == {ADDR_W{1'b1}});
  assign wr_count = wr_count_q;
  assign full     = full_w;
  assign dst_data = dst_mem[dst_addr];

endmodule

// File: tb/tb_scan_datapath.sv
// Bench for scan_datapath: directed scenarios plus a random phase, all
// checked against a behavioural model of the two RAMs and two counters.
module tb_scan_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0, rd_inc = 1'b0, wr_inc = 1'b0, we = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [7:0] load_data = 8'd0;
  logic [3:0] dst_addr = 4'd0;
  logic [3:0] rd_addr;
  logic [7:0] src_data;
  logic       gt, rco, full;
  logic [4:0] wr_count;
  logic [7:0] dst_data;

  scan_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rd_inc(rd_inc), .wr_inc(wr_inc), .we(we),
    .thresh(thresh), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dst_addr(dst_addr), .rd_addr(rd_addr), .src_data(src_data), .gt(gt), .rco(rco),
    .wr_count(wr_count), .full(full), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  // reference model
  logic [7:0] src_m [16];
  logic [7:0] dst_m [16];
  bit         dst_v [16];
  int         m_rd = 0;
  int         m_wr = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_gt();
    return src_m[m_rd] > thresh;
  endfunction

  task automatic check_all();
    chk("rd_addr", 32'(rd_addr), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("full", 32'(full), 32'(m_wr == 16));
    chk("rco", 32'(rco), 32'(m_rd == 15));
    chk("src_data", 32'(src_data), 32'(src_m[m_rd]));
    chk("gt", 32'(gt), 32'(m_gt()));
    if (dst_v[dst_addr]) chk("dst_data", 32'(dst_data), 32'(dst_m[dst_addr]));
  endtask

  // One clock: model consumes the inputs that were present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (we && !clr && m_wr < 16) begin
        dst_m[m_wr] = src_m[m_rd];
        dst_v[m_wr] = 1'b1;
      end
      if (load_en) src_m[load_addr] = load_data;
      if (clr) m_rd = 0;
      else if (rd_inc) m_rd = (m_rd + 1) % 16;
      if (clr) m_wr = 0;
      else if (wr_inc && m_wr < 16) m_wr = m_wr + 1;
    end
    #1;
  endtask

  task automatic cycle();
    #1;
    check_all();
    tick();
  endtask

  task automatic idle();
    clr = 0; rd_inc = 0; wr_inc = 0; we = 0; load_en = 0;
  endtask

  task automatic load_word(input int a, input logic [7:0] d);
    idle();
    load_en = 1; load_addr = 4'(a); load_data = d;
    cycle();
    load_en = 0;
  endtask

  task automatic do_clr();
    idle(); clr = 1; cycle(); clr = 0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    m_rd = 0; m_wr = 0;
    check_all();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    #12;
    m_rd = 0; m_wr = 0;
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rco", 32'(rco), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // preload mem[i] = i*16
    for (int i = 0; i < 16; i++) load_word(i, 8'(i * 16));

    // full scan with we = wr_inc = gt
    thresh = 8'd100;
    do_clr();
    for (int i = 0; i < 16; i++) begin
      idle();
      rd_inc = 1;
      we = m_gt(); wr_inc = m_gt();
      cycle();
    end
    idle();
    #1;
    chk("scan_wr_count", 32'(wr_count), 32'd9);
    chk("scan_rd_wrap", 32'(rd_addr), 32'd0);
    for (int k = 0; k < 9; k++) begin
      dst_addr = 4'(k);
      #1;
      chk("scan_dst", 32'(dst_data), 32'(112 + 16 * k));
    end
    tick();

    // mid-run reset with rd_addr=5, wr_count=3
    do_clr();
    for (int i = 0; i < 5; i++) begin
      idle(); rd_inc = 1; wr_inc = (i < 3); cycle();
    end
    idle();
    #1;
    chk("pre_rst_rd", 32'(rd_addr), 32'd5);
    chk("pre_rst_wr", 32'(wr_count), 32'd3);
    async_reset();
    chk("mid_rst_rd", 32'(rd_addr), 32'd0);
    chk("mid_rst_wr", 32'(wr_count), 32'd0);
    tick();

    // compare boundary at rd_addr = 0
    load_word(0, 8'd100);
    thresh = 8'd100;
    #1; chk("gt_equal", 32'(gt), 32'd0);
    load_word(0, 8'd101);
    #1; chk("gt_above", 32'(gt), 32'd1);
    thresh = 8'd255;
    for (int i = 0; i < 16; i++) begin
      idle(); rd_inc = 1;
      #1; chk("gt_max_thresh", 32'(gt), 32'd0);
      cycle();
    end

    // saturation
    for (int i = 0; i < 16; i++) load_word(i, 8'hFF);
    thresh = 8'd0;
    do_clr();
    for (int i = 0; i < 16; i++) begin
      idle(); we = 1; wr_inc = 1; rd_inc = 1; cycle();
    end
    for (int i = 0; i < 16; i++) load_word(i, 8'h22);
    for (int i = 0; i < 4; i++) begin
      idle(); we = 1; wr_inc = 1; rd_inc = 1; cycle();
    end
    idle();
    dst_addr = 4'd0;
    #1;
    chk("sat_wr_count", 32'(wr_count), 32'd16);
    chk("sat_full", 32'(full), 32'd1);
    chk("sat_dst0", 32'(dst_data), 32'hFF);
    tick();

    // clr dominates we/wr_inc/rd_inc
    for (int i = 0; i < 16; i++) load_word(i, 8'h33);
    do_clr();
    for (int i = 0; i < 4; i++) begin
      idle(); we = 1; wr_inc = 1; rd_inc = 1; cycle();
    end
    idle(); clr = 1; we = 1; wr_inc = 1; rd_inc = 1;
    cycle();
    idle();
    dst_addr = 4'd4;
    #1;
    chk("prio_rd", 32'(rd_addr), 32'd0);
    chk("prio_wr", 32'(wr_count), 32'd0);
    chk("prio_dst4", 32'(dst_data), 32'hFF);
    tick();

    // load/read collision at rd_addr = 3
    for (int i = 0; i < 3; i++) begin
      idle(); rd_inc = 1; cycle();
    end
    idle();
    thresh = 8'h40;
    load_en = 1; load_addr = 4'd3; load_data = 8'h55;
    #1;
    chk("coll_old_src", 32'(src_data), 32'h33);
    chk("coll_old_gt", 32'(gt), 32'd0);
    tick();
    load_en = 0;
    #1;
    chk("coll_new_src", 32'(src_data), 32'h55);
    chk("coll_new_gt", 32'(gt), 32'd1);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      clr       = ($urandom_range(0, 15) == 0);
      rd_inc    = $urandom_range(0, 1);
      wr_inc    = $urandom_range(0, 1);
      we        = $urandom_range(0, 1);
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = 4'($urandom);
      load_data = 8'($urandom);
      dst_addr  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) thresh = 8'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_datapath.md
Name: scan_datapath

Overview:
Datapath slaved to the scan controller FSM. It holds a preloadable source RAM, a read-address counter, a magnitude comparator against a threshold, a destination RAM and a write-address/match counter. It produces the controller's status inputs: rco (last address reached) and gt (current word exceeds threshold). It consumes the controller's clr, rd_inc, wr_inc and we strobes.

Parameters:
DATA_W, 8, width of each RAM word and of the threshold
ADDR_W, 4, address width; both RAMs hold 2**ADDR_W words

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous clear of both counters (controller start-of-scan)
rd_inc  in  1  advance read-address counter
wr_inc  in  1  advance write-address/match counter
we  in  1  write current source word into destination RAM
thresh  in  DATA_W  comparison threshold, unsigned
load_en  in  1  source RAM preload write enable
load_addr  in  ADDR_W  source RAM preload address
load_data  in  DATA_W  source RAM preload data
dst_addr  in  ADDR_W  destination RAM readback address
rd_addr  out  ADDR_W  current read address
src_data  out  DATA_W  source RAM word at rd_addr
gt  out  1  src_data > thresh
rco  out  1  rd_addr == 2**ADDR_W-1
wr_count  out  ADDR_W+1  number of words stored; also next destination address
full  out  1  wr_count == 2**ADDR_W
dst_data  out  DATA_W  destination RAM word at dst_addr

Behaviour:
- Reset (async, rst=1): rd_addr=0, wr_count=0. Hence rco=0 (ADDR_W>=1) and full=0. gt, src_data and dst_data follow RAM contents combinationally. RAM arrays are not reset.
- Both RAMs: synchronous write, asynchronous (combinational) read. src_data, gt, rco and dst_data are valid in the same cycle as their address. The controller samples gt/rco with zero latency.
- Source RAM write: on clk edge when load_en=1, mem[load_addr] <= load_data. It is independent of the scan. If load_addr==rd_addr, src_data shows the old word until after the edge.
- Read counter: clr=1 -> 0; else rd_inc=1 -> rd_addr+1, wrapping from 2**ADDR_W-1 to 0; else hold.
- rco asserts combinationally while rd_addr is at max. Wrap on rd_inc at max is legal and silent.
- gt is an unsigned strict compare; equal gives gt=0.
- Destination write: on edge when we=1, clr=0 and full=0, dst_mem[wr_count[ADDR_W-1:0]] <= src_data (value before the edge). If full=1, the write is dropped.
- Write counter: clr=1 -> 0; else wr_inc=1 and full=0 -> wr_count+1; else hold. It saturates at 2**ADDR_W; wr_inc while full is ignored.
- Simultaneous we and wr_inc: the write uses the pre-increment wr_count. The next match goes to the next slot.
- Priority: rst > clr > rd_inc/wr_inc/we. clr with we in the same cycle gives no write.
- rst asserted mid-scan: counters clear immediately (asynchronously) and RAM contents are retained. Scan resumes only on a new controller start.
- No internal FSM. Sequencing belongs to the controller. Outputs are purely a function of counters, RAMs and inputs.

Test Plan:
- Reset/idle: assert rst mid-run with rd_addr=5, wr_count=3 -> both read 0 before next edge; full=0; rco=0.
- Full scan: preload mem[i]=i*16 (i=0..15), thresh=100, clr then rd_inc for 16 cycles with we=wr_inc=gt -> wr_count=9, dst_mem[0..8]=112..240, rco high only at rd_addr=15, rd_addr wraps to 0.
- Compare boundary: mem[0]=100, thresh=100 -> gt=0. mem[0]=101 -> gt=1. thresh=255 -> gt=0 for all words.
- Saturation: all words 0xFF, thresh=0, 20 cycles of we=wr_inc=rd_inc=1 -> wr_count stops at 16, full=1, dst_mem[0] keeps first-pass value (not overwritten on wrap).
- Priority: clr=1 with we=wr_inc=rd_inc=1, wr_count=4 -> counters 0, dst_mem[4] unchanged.
- Load/read collision: rd_addr=3, load_en=1 to addr 3 with 0x55 -> src_data shows old value that cycle and 0x55 after the edge; gt updates accordingly.
